sync_rx_display: RTL

- Parametrised synchronous serial receiver with a multiplexed hex display.
- Samples data_point on edges of an external data_clk, gated by Enable, and assembles FRAME_BITS-bit frames in the clk domain.
- Presents each completed frame on a parallel output with a one-cycle valid strobe.
- Drives a multi-digit seven-segment display with the last received frame in hex.
- Successor to the single-bit, single-digit receiver; sits between the board serial header and the display.

---
 rtl/sync_rx_display_if.sv | 21 ++
 rtl/sync_rx_display.sv | 119 +++++++++++
 2 files changed

// File: rtl/sync_rx_display_if.sv
// sync_rx_display_if: serial pad inputs plus frame and display outputs of the receiver
//   master: drives data_clk/data_point/Enable, observes frame and display outputs
//   slave : the receiver side
interface sync_rx_display_if #(
    parameter int FRAME_BITS = 8,
    parameter int DIGITS     = 2
);
    logic                  data_clk;
    logic                  data_point;
    logic                  Enable;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  busy;
    logic [7:0]            frame_count;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig;
    modport master(output data_clk, data_point, Enable,
                   input frame_data, frame_valid, busy, frame_count, seg, dig);
    modport slave(input data_clk, data_point, Enable,
                  output frame_data, frame_valid, busy, frame_count, seg, dig);
endinterface

// File: rtl/sync_rx_display.sv
// sync_rx_display: synchronous serial frame receiver with multiplexed hex display
//   clk, rst            : system clock, synchronous active-high reset
//   bus.data_clk/point  : asynchronous serial clock and data, bus.Enable receive enable
//   bus.frame_data/valid: last completed frame and its one-cycle strobe
//   bus.busy            : partial frame held, bus.frame_count completed frames
//   bus.seg/dig         : active-low segments (dp, g..a) and one-hot digit select
module sync_rx_display #(
    parameter int FRAME_BITS    = 8,
    parameter int MSB_FIRST     = 1,
    parameter int SAMPLE_RISING = 1,
    parameter int DIGITS        = 2,
    parameter int REFRESH_DIV   = 50000
) (
    input logic clk,
    input logic rst,
    sync_rx_display_if.slave bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [FRAME_BITS-1:0] sr, sr_n, shifted, frame_data;
    logic [7:0]            frame_count;
    logic [2:0]            clk_s;
    logic [1:0]            dat_s, en_s;
    logic                  smp;
    logic [RW-1:0]         rcnt;
    logic [IW-1:0]         idx;
    logic [DIGITS*4-1:0]   padded;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    // Synchronisers carry no reset so an idle-high data_clk cannot fake an edge after rst.
    always_ff @(posedge clk) begin
        clk_s <= {clk_s[1:0], bus.data_clk};
        dat_s <= {dat_s[0], bus.data_point};
        en_s  <= {en_s[0], bus.Enable};
    end
    assign smp = en_s[1] & (SAMPLE_RISING != 0 ? clk_s[1] & ~clk_s[2] : ~clk_s[1] & clk_s[2]);
    assign shifted = MSB_FIRST != 0 ? {sr[FRAME_BITS-2:0], dat_s[1]} : {dat_s[1], sr[FRAME_BITS-1:1]};
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        case (state)
            IDLE: if (smp) begin
                sr_n    = shifted;
                cnt_n   = CW'(1);
                state_n = SHIFT;
            end
            SHIFT: if (!en_s[1]) begin
                cnt_n   = '0;
                state_n = IDLE;
            end else if (smp) begin
                sr_n    = shifted;
                cnt_n   = cnt + CW'(1);
                state_n = cnt_n == CW'(FRAME_BITS) ? DONE : SHIFT;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end
    // frame_data and frame_count update on entry to DONE so they line up with frame_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            frame_data  <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sr          <= sr_n;
            frame_data  <= state_n == DONE ? sr_n : frame_data;
            frame_count <= frame_count + {7'd0, state_n == DONE};
        end
    end
    assign bus.frame_data  = frame_data;
    assign bus.frame_count = frame_count;
    assign bus.frame_valid = state == DONE;
    assign bus.busy        = state == SHIFT;
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else begin
            rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + RW'(1);
            idx  <= rcnt != RW'(REFRESH_DIV - 1) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
        end
    end
    assign padded = (DIGITS*4)'(frame_data);
    assign nib    = padded[{idx, 2'b00} +: 4];
    always_comb begin
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end
    assign bus.seg = {~(state == SHIFT && idx == '0), glyph};
    assign bus.dig = ~(DIGITS'(1) << idx);
endmodule
